// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS main controller: sequences fetch/decode/execute/memory/write-back
// and drives every datapath select and enable from the current state and IR fields.
module mc_ctrl_fsm #(
    parameter bit ILLEGAL_HALT = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] func,
    input  logic       alu_zero,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    output logic       imem_req,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic [1:0] alu_src_b,
    output logic [3:0] alu_op,
    output logic       reg_we,
    output logic [1:0] reg_dst,
    output logic [1:0] wb_src,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] state_dbg
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC     = 4'd2,
        MEM_ADDR = 4'd3,
        MEM_RD   = 4'd4,
        MEM_WR   = 4'd5,
        WB       = 4'd6,
        BRANCH   = 4'd7,
        JUMP     = 4'd8,
        ILLEGAL  = 4'd9
    } state_e;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_SLT = 4'd4;
    localparam logic [3:0] ALU_SLL = 4'd5;
    localparam logic [3:0] ALU_LUI = 4'd6;

    state_e r_state;
    state_e w_nextState;

    logic w_isR, w_rAlu, w_jr, w_addiu, w_iAlu, w_lw, w_sw, w_beq, w_bne, w_j, w_jal;

    always_comb begin
        w_isR   = (opcode == 6'h00);
        w_rAlu  = w_isR && ((func == 6'h21) || (func == 6'h23) || (func == 6'h24) ||
                            (func == 6'h25) || (func == 6'h2A) || (func == 6'h00));
        w_jr    = w_isR && (func == 6'h08);
        w_addiu = (opcode == 6'h09);
        w_iAlu  = w_addiu || (opcode == 6'h0C) || (opcode == 6'h0D) || (opcode == 6'h0F);
        w_lw    = (opcode == 6'h23);
        w_sw    = (opcode == 6'h2B);
        w_beq   = (opcode == 6'h04);
        w_bne   = (opcode == 6'h05);
        w_j     = (opcode == 6'h02);
        w_jal   = (opcode == 6'h03);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Reset forces every output low, so an abandoned memory request drops immediately.
    always_comb begin
        w_nextState = r_state;
        imem_req    = 1'b0;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        pc_src      = 2'b00;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        alu_src_b   = 2'b00;
        alu_op      = ALU_ADD;
        reg_we      = 1'b0;
        reg_dst     = 2'b00;
        wb_src      = 2'b00;
        instr_done  = 1'b0;
        illegal     = 1'b0;
        state_dbg   = 4'd0;
        if (rst) begin
            w_nextState = FETCH;
        end else begin
            state_dbg = r_state;
            case (r_state)
                FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        ir_we       = 1'b1;
                        pc_we       = 1'b1;
                        w_nextState = DECODE;
                    end
                end
                DECODE: begin
                    if (w_rAlu || w_iAlu)          w_nextState = EXEC;
                    else if (w_lw || w_sw)         w_nextState = MEM_ADDR;
                    else if (w_beq || w_bne)       w_nextState = BRANCH;
                    else if (w_jr || w_j || w_jal) w_nextState = JUMP;
                    else                           w_nextState = ILLEGAL;
                end
                EXEC: begin
                    if (w_isR) begin
                        alu_src_b = 2'b00;
                        case (func)
                            6'h23:   alu_op = ALU_SUB;
                            6'h24:   alu_op = ALU_AND;
                            6'h25:   alu_op = ALU_OR;
                            6'h2A:   alu_op = ALU_SLT;
                            6'h00:   alu_op = ALU_SLL;
                            default: alu_op = ALU_ADD;
                        endcase
                    end else begin
                        alu_src_b = w_addiu ? 2'b01 : 2'b10;
                        case (opcode)
                            6'h0C:   alu_op = ALU_AND;
                            6'h0D:   alu_op = ALU_OR;
                            6'h0F:   alu_op = ALU_LUI;
                            default: alu_op = ALU_ADD;
                        endcase
                    end
                    w_nextState = WB;
                end
                MEM_ADDR: begin
                    alu_src_b   = 2'b01;
                    w_nextState = w_lw ? MEM_RD : MEM_WR;
                end
                MEM_RD: begin
                    dmem_req = 1'b1;
                    if (dmem_ready) w_nextState = WB;
                end
                MEM_WR: begin
                    dmem_req = 1'b1;
                    dmem_we  = 1'b1;
                    if (dmem_ready) begin
                        instr_done  = 1'b1;
                        w_nextState = FETCH;
                    end
                end
                WB: begin
                    reg_we      = 1'b1;
                    wb_src      = w_lw ? 2'b01 : 2'b00;
                    reg_dst     = w_isR ? 2'b01 : 2'b00;
                    instr_done  = 1'b1;
                    w_nextState = FETCH;
                end
                BRANCH: begin
                    alu_op      = ALU_SUB;
                    pc_src      = 2'b01;
                    pc_we       = w_bne ? ~alu_zero : alu_zero;
                    instr_done  = 1'b1;
                    w_nextState = FETCH;
                end
                JUMP: begin
                    pc_we  = 1'b1;
                    pc_src = w_jr ? 2'b11 : 2'b10;
                    if (w_jal) begin
                        reg_we  = 1'b1;
                        reg_dst = 2'b10;
                        wb_src  = 2'b10;
                    end
                    instr_done  = 1'b1;
                    w_nextState = FETCH;
                end
                ILLEGAL: begin
                    illegal     = 1'b1;
                    w_nextState = ILLEGAL_HALT ? ILLEGAL : FETCH;
                end
                default: w_nextState = FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Table-driven bench for mc_ctrl_fsm: one vector per clock, outputs compared as a packed bundle.
module tb_mc_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode, func;
    logic       alu_zero, imem_ready, dmem_ready;

    logic       imem_req, ir_we, pc_we, dmem_req, dmem_we, reg_we, instr_done, illegal;
    logic [1:0] pc_src, alu_src_b, reg_dst, wb_src;
    logic [3:0] alu_op, state_dbg;

    logic       imem_req0, ir_we0, pc_we0, dmem_req0, dmem_we0, reg_we0, instr_done0, illegal0;
    logic [1:0] pc_src0, alu_src_b0, reg_dst0, wb_src0;
    logic [3:0] alu_op0, state_dbg0;

    int nChecks = 0;
    int nErrors = 0;

    always #5 clk = ~clk;

    mc_ctrl_fsm #(.ILLEGAL_HALT(1'b1)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .func(func), .alu_zero(alu_zero),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req),
        .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_we(reg_we),
        .reg_dst(reg_dst), .wb_src(wb_src), .instr_done(instr_done),
        .illegal(illegal), .state_dbg(state_dbg)
    );

    mc_ctrl_fsm #(.ILLEGAL_HALT(1'b0)) dutSkip (
        .clk(clk), .rst(rst), .opcode(opcode), .func(func), .alu_zero(alu_zero),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req0),
        .ir_we(ir_we0), .pc_we(pc_we0), .pc_src(pc_src0), .dmem_req(dmem_req0),
        .dmem_we(dmem_we0), .alu_src_b(alu_src_b0), .alu_op(alu_op0), .reg_we(reg_we0),
        .reg_dst(reg_dst0), .wb_src(wb_src0), .instr_done(instr_done0),
        .illegal(illegal0), .state_dbg(state_dbg0)
    );

    wire [23:0] actual = {state_dbg, imem_req, ir_we, pc_we, pc_src, dmem_req, dmem_we,
                          alu_src_b, alu_op, reg_we, reg_dst, wb_src, instr_done, illegal};
    wire [23:0] actualSkip = {state_dbg0, imem_req0, ir_we0, pc_we0, pc_src0, dmem_req0,
                              dmem_we0, alu_src_b0, alu_op0, reg_we0, reg_dst0, wb_src0,
                              instr_done0, illegal0};

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic        ir;
        logic        dr;
        logic [23:0] exp;
    } vec_t;

    vec_t vecs[$];

    // Field order: state, imem_req, ir_we, pc_we, pc_src, dmem_req, dmem_we,
    // alu_src_b, alu_op, reg_we, reg_dst, wb_src, instr_done, illegal.
    function automatic logic [23:0] ex(input logic [3:0] st, input logic ireq, irwe, pcwe,
                                       input logic [1:0] pcsrc, input logic dreq, dwe,
                                       input logic [1:0] asrc, input logic [3:0] aop,
                                       input logic rwe, input logic [1:0] rdst, wsrc,
                                       input logic done, ill);
        return {st, ireq, irwe, pcwe, pcsrc, dreq, dwe, asrc, aop, rwe, rdst, wsrc, done, ill};
    endfunction

    task automatic add(input logic r, input logic [5:0] op, fn, input logic z, ir, dr,
                       input logic [23:0] e);
        vec_t v;
        v.rst = r; v.op = op; v.fn = fn; v.z = z; v.ir = ir; v.dr = dr; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic addFetchDecode(input logic [5:0] op, fn);
        add(0, op, fn, 0, 1, 0, ex(4'd0, 1, 1, 1, 2'd0, 0, 0, 2'd0, 4'd0, 0, 2'd0, 2'd0, 0, 0));
        add(0, op, fn, 0, 0, 0, ex(4'd1, 0, 0, 0, 2'd0, 0, 0, 2'd0, 4'd0, 0, 2'd0, 2'd0, 0, 0));
    endtask

    task automatic addAlu(input logic [5:0] op, fn, input logic [3:0] aop,
                          input logic [1:0] asrc, rdst);
        addFetchDecode(op, fn);
        add(0, op, fn, 0, 0, 0, ex(4'd2, 0, 0, 0, 2'd0, 0, 0, asrc, aop, 0, 2'd0, 2'd0, 0, 0));
        add(0, op, fn, 0, 0, 0, ex(4'd6, 0, 0, 0, 2'd0, 0, 0, 2'd0, 4'd0, 1, rdst, 2'd0, 1, 0));
    endtask

    task automatic addBranch(input logic [5:0] op, input logic z, pcwe);
        addFetchDecode(op, 6'h00);
        add(0, op, 6'h00, z, 0, 0, ex(4'd7, 0, 0, pcwe, 2'd1, 0, 0, 2'd0, 4'd1, 0, 2'd0, 2'd0, 1, 0));
    endtask

    task automatic addJump(input logic [5:0] op, fn, input logic [1:0] pcsrc, input logic link);
        addFetchDecode(op, fn);
        add(0, op, fn, 0, 0, 0, ex(4'd8, 0, 0, 1, pcsrc, 0, 0, 2'd0, 4'd0, link,
                                   link ? 2'd2 : 2'd0, link ? 2'd2 : 2'd0, 1, 0));
    endtask

    task automatic applyStimulus(input logic r, input logic [5:0] op, fn, input logic z, ir, dr);
        rst = r; opcode = op; func = fn; alu_zero = z; imem_ready = ir; dmem_ready = dr;
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [23:0] act, input logic [23:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [23:0] memAddr, memRd, memWr, illegalSt, fetchWait;
        memAddr   = ex(4'd3, 0, 0, 0, 2'd0, 0, 0, 2'd1, 4'd0, 0, 2'd0, 2'd0, 0, 0);
        memRd     = ex(4'd4, 0, 0, 0, 2'd0, 1, 0, 2'd0, 4'd0, 0, 2'd0, 2'd0, 0, 0);
        memWr     = ex(4'd5, 0, 0, 0, 2'd0, 1, 1, 2'd0, 4'd0, 0, 2'd0, 2'd0, 0, 0);
        illegalSt = ex(4'd9, 0, 0, 0, 2'd0, 0, 0, 2'd0, 4'd0, 0, 2'd0, 2'd0, 0, 1);
        fetchWait = ex(4'd0, 1, 0, 0, 2'd0, 0, 0, 2'd0, 4'd0, 0, 2'd0, 2'd0, 0, 0);

        for (int i = 0; i < 3; i++) add(1, 6'h00, 6'h21, 0, 1, 0, 24'h0);
        addAlu(6'h00, 6'h21, 4'd0, 2'd0, 2'd1);
        // lw with two wait cycles on the data memory
        addFetchDecode(6'h23, 6'h00);
        add(0, 6'h23, 6'h00, 0, 0, 0, memAddr);
        add(0, 6'h23, 6'h00, 0, 0, 0, memRd);
        add(0, 6'h23, 6'h00, 0, 0, 0, memRd);
        add(0, 6'h23, 6'h00, 0, 0, 1, memRd);
        add(0, 6'h23, 6'h00, 0, 0, 0, ex(4'd6, 0, 0, 0, 2'd0, 0, 0, 2'd0, 4'd0, 1, 2'd0, 2'd1, 1, 0));
        // sw after an instruction-memory stall; stray dmem_ready must be ignored in FETCH
        add(0, 6'h2B, 6'h00, 0, 0, 1, fetchWait);
        addFetchDecode(6'h2B, 6'h00);
        add(0, 6'h2B, 6'h00, 0, 0, 0, memAddr);
        add(0, 6'h2B, 6'h00, 0, 0, 1, memWr | 24'h2);
        addAlu(6'h00, 6'h23, 4'd1, 2'd0, 2'd1);
        addAlu(6'h00, 6'h24, 4'd2, 2'd0, 2'd1);
        addAlu(6'h00, 6'h25, 4'd3, 2'd0, 2'd1);
        addAlu(6'h00, 6'h2A, 4'd4, 2'd0, 2'd1);
        addAlu(6'h00, 6'h00, 4'd5, 2'd0, 2'd1);
        addAlu(6'h09, 6'h00, 4'd0, 2'd1, 2'd0);
        addAlu(6'h0C, 6'h00, 4'd2, 2'd2, 2'd0);
        addAlu(6'h0D, 6'h00, 4'd3, 2'd2, 2'd0);
        addAlu(6'h0F, 6'h00, 4'd6, 2'd2, 2'd0);
        addBranch(6'h04, 1, 1);
        addBranch(6'h05, 1, 0);
        addBranch(6'h04, 0, 0);
        addBranch(6'h05, 0, 1);
        addJump(6'h03, 6'h00, 2'd2, 1);
        addJump(6'h02, 6'h00, 2'd2, 0);
        addJump(6'h00, 6'h08, 2'd3, 0);
        // reset while a store request is pending
        addFetchDecode(6'h2B, 6'h00);
        add(0, 6'h2B, 6'h00, 0, 0, 0, memAddr);
        add(0, 6'h2B, 6'h00, 0, 0, 0, memWr);
        add(1, 6'h2B, 6'h00, 0, 0, 0, 24'h0);
        add(0, 6'h2B, 6'h00, 0, 0, 0, fetchWait);
        addFetchDecode(6'h3F, 6'h00);
        for (int i = 0; i < 3; i++) add(0, 6'h3F, 6'h00, 0, 1, 1, illegalSt);
        add(1, 6'h00, 6'h00, 0, 0, 0, 24'h0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].op, vecs[i].fn, vecs[i].z, vecs[i].ir, vecs[i].dr);
            checkOutput($sformatf("vec%0d", i), actual, vecs[i].exp);
            @(posedge clk); #1;
        end

        // Illegal R-type func: halting instance stays trapped, skipping instance refetches
        applyStimulus(0, 6'h00, 6'h3F, 0, 1, 0);
        @(posedge clk); #1;
        applyStimulus(0, 6'h00, 6'h3F, 0, 1, 0);
        @(posedge clk); #1;
        applyStimulus(0, 6'h00, 6'h3F, 0, 1, 0);
        checkOutput("haltIllegal", actual, illegalSt);
        checkOutput("skipIllegal", actualSkip, illegalSt);
        @(posedge clk); #1;
        applyStimulus(0, 6'h00, 6'h3F, 0, 1, 0);
        checkOutput("haltStays", actual, illegalSt);
        checkOutput("skipRefetch", actualSkip,
                    ex(4'd0, 1, 1, 1, 2'd0, 0, 0, 2'd0, 4'd0, 0, 2'd0, 2'd0, 0, 0));
        @(posedge clk); #1;
        applyStimulus(0, 6'h00, 6'h3F, 0, 1, 0);
        checkOutput("haltStill", actual, illegalSt);
        checkOutput("skipDecode", actualSkip,
                    ex(4'd1, 0, 0, 0, 2'd0, 0, 0, 2'd0, 4'd0, 0, 2'd0, 2'd0, 0, 0));

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
